// File: rtl/datamem_arbiter_pkg.sv
// Shared types, widths and the round-robin search used by the datamem arbiter.
package datamem_arb_pkg;

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned MAX_REQ = 8;
   localparam int unsigned IDX_W   = 3;

   typedef enum logic {S_CLEAR, S_RUN} state_e;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // First valid index at or after ptr, wrapping at n (ptr < n <= MAX_REQ).
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                     input logic [IDX_W-1:0]   ptr,
                                     input logic [IDX_W:0]     n);
      pick_t      r;
      logic [IDX_W:0] k;
      r = '0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         if ((IDX_W+1)'(i) < n) begin
            k = {1'b0, ptr} + (IDX_W+1)'(i);
            if (k >= n) k = k - n;
            if (!r.found && valid[k[IDX_W-1:0]]) begin
               r.found = 1'b1;
               r.idx   = k[IDX_W-1:0];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/datamem_arbiter_if.sv
// Requester, response and datamem signals of the arbiter; slave = arbiter side.
interface datamem_arbiter_if
   import datamem_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ID_W    = 3
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ-1:0]        req_lock;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        req_ready;

   logic                      rsp_valid;
   logic [ID_W-1:0]           rsp_id;
   logic                      rsp_write;
   logic [DATA_W-1:0]         rsp_rdata;

   logic [ADDR_W-1:0]         mem_address;
   logic                      mem_write_enable;
   logic                      mem_read_enable;
   logic [DATA_W-1:0]         mem_write_data;
   logic [DATA_W-1:0]         mem_read_data;
   logic                      mem_reset;

   modport slave (
      input  req_valid, req_write, req_lock, req_addr, req_wdata, mem_read_data,
      output req_ready, rsp_valid, rsp_id, rsp_write, rsp_rdata,
             mem_address, mem_write_enable, mem_read_enable, mem_write_data, mem_reset
   );

   modport master (
      output req_valid, req_write, req_lock, req_addr, req_wdata, mem_read_data,
      input  req_ready, rsp_valid, rsp_id, rsp_write, rsp_rdata,
             mem_address, mem_write_enable, mem_read_enable, mem_write_data, mem_reset
   );

endinterface

// File: rtl/datamem_arbiter_rr_picker.sv
// Combinational round-robin priority search over NUM_REQ request lines.
module rr_picker
   import datamem_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_found
);
   logic [MAX_REQ-1:0] w_valid;
   pick_t              w_pick;

   always_comb begin
      w_valid                = '0;
      w_valid[NUM_REQ-1:0]   = i_valid;
      w_pick                 = rr_pick(w_valid, i_ptr, (IDX_W+1)'(NUM_REQ));
      o_idx                  = w_pick.idx;
      o_found                = w_pick.found;
   end

endmodule

// File: rtl/datamem_arbiter.sv
// Round-robin arbiter sharing one datamem port among NUM_REQ requesters, with
// optional lock, one-cycle registered responses and a post-reset memory clear.
module datamem_arbiter
   import datamem_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ID_W    = 3
) (
   input logic              clk,
   input logic              reset,
   datamem_arbiter_if.slave bus
);
   state_e             r_state, w_state_next;
   logic [IDX_W-1:0]   r_rr_ptr, r_lock_id;
   logic               r_lock_vld;
   logic               r_rsp_valid, r_rsp_write;
   logic [ID_W-1:0]    r_rsp_id;
   logic [DATA_W-1:0]  r_rsp_rdata;

   logic [IDX_W-1:0]   w_pick_idx, w_gnt, w_ptr_next;
   logic               w_pick_found, w_run, w_lock_hit, w_xfer, w_hold_ptr;
   logic [MAX_REQ-1:0] w_valid, w_write, w_lock;
   logic [ADDR_W-1:0]  w_addr  [MAX_REQ];
   logic [DATA_W-1:0]  w_wdata [MAX_REQ];

   // Pad the packed request buses to MAX_REQ so the grant index can select freely.
   for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_pad
      if (gi < NUM_REQ) begin : g_on
         assign w_valid[gi] = bus.req_valid[gi];
         assign w_write[gi] = bus.req_write[gi];
         assign w_lock[gi]  = bus.req_lock[gi];
         assign w_addr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
         assign w_wdata[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
      end else begin : g_off
         assign w_valid[gi] = 1'b0;
         assign w_write[gi] = 1'b0;
         assign w_lock[gi]  = 1'b0;
         assign w_addr[gi]  = '0;
         assign w_wdata[gi] = '0;
      end
   end

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .i_valid (bus.req_valid),
      .i_ptr   (r_rr_ptr),
      .o_idx   (w_pick_idx),
      .o_found (w_pick_found)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_CLEAR;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (r_state == S_CLEAR) w_state_next = S_RUN;

      w_run      = (r_state == S_RUN);
      w_lock_hit = r_lock_vld && w_valid[r_lock_id];
      w_gnt      = w_lock_hit ? r_lock_id : w_pick_idx;
      w_xfer     = w_run && (w_lock_hit || w_pick_found);
      // Pointer stays put while the owner keeps its lock.
      w_hold_ptr = w_lock_hit && w_lock[w_gnt];
      w_ptr_next = (w_gnt == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;

      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         bus.req_ready[i] = w_xfer && (w_gnt == IDX_W'(i));
      end
      bus.mem_address      = w_addr[w_gnt];
      bus.mem_write_data   = w_wdata[w_gnt];
      bus.mem_write_enable = w_xfer && w_write[w_gnt];
      bus.mem_read_enable  = w_xfer && !w_write[w_gnt];
      bus.mem_reset        = (r_state == S_CLEAR);

      bus.rsp_valid = r_rsp_valid;
      bus.rsp_id    = r_rsp_id;
      bus.rsp_write = r_rsp_write;
      bus.rsp_rdata = r_rsp_rdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rr_ptr    <= '0;
         r_lock_vld  <= 1'b0;
         r_lock_id   <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= '0;
      end else if (w_run) begin
         r_rsp_valid <= w_xfer;
         r_rsp_id    <= ID_W'(w_gnt);
         r_rsp_write <= w_write[w_gnt];
         r_rsp_rdata <= w_write[w_gnt] ? '0 : bus.mem_read_data;
         // An owner that is not granted has dropped valid, so the lock lapses.
         r_lock_vld  <= w_xfer && w_lock[w_gnt];
         r_lock_id   <= w_gnt;
         if (w_xfer && !w_hold_ptr) r_rr_ptr <= w_ptr_next;
      end
   end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter with two requesters and a datamem model.
module tb_datamem_arbiter;

   logic clk;
   logic reset;
   int   n_run  = 0;
   int   n_fail = 0;

   datamem_arbiter_if #(.NUM_REQ(2), .ID_W(3)) bus_if ();

   datamem_arbiter #(
      .NUM_REQ (2),
      .ID_W    (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // datamem model: synchronous clear loads word 0 with 441A, combinational read.
   logic [15:0] mem [65536];
   always @(posedge clk) begin
      if (bus_if.mem_reset) begin
         for (int i = 1; i < 65536; i++) mem[i] <= 16'h0000;
         mem[0] <= 16'h441A;
      end else if (bus_if.mem_write_enable) begin
         mem[bus_if.mem_address] <= bus_if.mem_write_data;
      end
   end
   assign bus_if.mem_read_data = mem[bus_if.mem_address];

   typedef struct {
      logic [1:0]  v, w, l;
      logic [15:0] a0, a1, d0, d1;
      logic [1:0]  rdy;
      logic        we, re;
      logic [15:0] addr;
      logic        rv;
      logic [2:0]  rid;
      logic        rw;
      logic [15:0] rd;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [1:0] v, w, l, input logic [15:0] a0, a1, d0, d1,
                      input logic [1:0] rdy, input logic we, re, input logic [15:0] addr,
                      input logic rv, input logic [2:0] rid, input logic rw,
                      input logic [15:0] rd);
      vec_t x;
      x.v = v; x.w = w; x.l = l; x.a0 = a0; x.a1 = a1; x.d0 = d0; x.d1 = d1;
      x.rdy = rdy; x.we = we; x.re = re; x.addr = addr;
      x.rv = rv; x.rid = rid; x.rw = rw; x.rd = rd;
      vecs.push_back(x);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, w, l, input logic [15:0] a0, a1, d0, d1);
      bus_if.req_valid = v;
      bus_if.req_write = w;
      bus_if.req_lock  = l;
      bus_if.req_addr  = {a1, a0};
      bus_if.req_wdata = {d1, d0};
   endtask

   initial begin
      vec_t x;
      //   v      w      l      a0       a1       d0       d1       rdy   we re addr     rv id rw rd
      add(2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b01, 0, 1, 16'h0000, 1, 0, 0, 16'h441A);
      add(2'b10, 2'b00, 2'b00, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 2'b10, 0, 1, 16'h0005, 1, 1, 0, 16'h0000);
      add(2'b01, 2'b01, 2'b00, 16'h0010, 16'h0000, 16'hBEEF, 16'h0000, 2'b01, 1, 0, 16'h0010, 1, 0, 1, 16'h0000);
      add(2'b01, 2'b00, 2'b00, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 2'b01, 0, 1, 16'h0010, 1, 0, 0, 16'hBEEF);
      // Fairness: pointer is 1 here, so grants alternate 1,0,1,0,1,0.
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0)
            add(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0000, 16'h0, 16'h0, 2'b10, 0, 1, 16'h0000, 1, 1, 0, 16'h441A);
         else
            add(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0000, 16'h0, 16'h0, 2'b01, 0, 1, 16'h0010, 1, 0, 0, 16'hBEEF);
      end
      // Lock: req1 read+lock, then write while still owner, then req0 wins.
      add(2'b11, 2'b00, 2'b10, 16'h0010, 16'h0020, 16'h0000, 16'h0000, 2'b10, 0, 1, 16'h0020, 1, 1, 0, 16'h0000);
      add(2'b11, 2'b10, 2'b00, 16'h0010, 16'h0020, 16'h0000, 16'h0005, 2'b10, 1, 0, 16'h0020, 1, 1, 1, 16'h0000);
      add(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0000, 16'h0000, 2'b01, 0, 1, 16'h0010, 1, 0, 0, 16'hBEEF);
      add(2'b10, 2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0000, 16'h0000, 2'b10, 0, 1, 16'h0020, 1, 1, 0, 16'h0005);
      // Idle gap: pointer (0) must survive it.
      for (int i = 0; i < 3; i++)
         add(2'b00, 2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0, 16'h0, 2'b00, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
      add(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0000, 16'h0000, 2'b01, 0, 1, 16'h0010, 1, 0, 0, 16'hBEEF);
      // Lock without valid is ignored.
      add(2'b01, 2'b00, 2'b10, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 2'b01, 0, 1, 16'h0000, 1, 0, 0, 16'h441A);
      add(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0000, 16'h0000, 2'b10, 0, 1, 16'h0020, 1, 1, 0, 16'h0005);
      // req0 holds the lock across three grants.
      add(2'b11, 2'b00, 2'b01, 16'h0010, 16'h0020, 16'h0000, 16'h0000, 2'b01, 0, 1, 16'h0010, 1, 0, 0, 16'hBEEF);
      add(2'b11, 2'b00, 2'b01, 16'h0010, 16'h0020, 16'h0000, 16'h0000, 2'b01, 0, 1, 16'h0010, 1, 0, 0, 16'hBEEF);
      add(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0000, 16'h0000, 2'b01, 0, 1, 16'h0010, 1, 0, 0, 16'hBEEF);
      add(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0000, 16'h0000, 2'b10, 0, 1, 16'h0020, 1, 1, 0, 16'h0005);

      // Power-on reset with requests pending.
      reset = 1'b0;
      drive(2'b11, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("rst_mem_reset", -1, bus_if.mem_reset, 1);
         chk("rst_ready", -1, bus_if.req_ready, 0);
         chk("rst_rsp_valid", -1, bus_if.rsp_valid, 0);
         chk("rst_mem_en", -1, {bus_if.mem_write_enable, bus_if.mem_read_enable}, 0);
      end
      reset = 1'b1;
      @(negedge clk);
      chk("clear_mem_reset", -1, bus_if.mem_reset, 1);
      chk("clear_ready", -1, bus_if.req_ready, 0);
      @(posedge clk); #1;
      chk("run_mem_reset", -1, bus_if.mem_reset, 0);
      chk("run_rsp_valid", -1, bus_if.rsp_valid, 0);

      foreach (vecs[i]) begin
         x = vecs[i];
         drive(x.v, x.w, x.l, x.a0, x.a1, x.d0, x.d1);
         @(negedge clk);
         chk("ready", i, bus_if.req_ready, x.rdy);
         chk("mem_we", i, bus_if.mem_write_enable, x.we);
         chk("mem_re", i, bus_if.mem_read_enable, x.re);
         if (x.rdy != 2'b00) chk("mem_addr", i, bus_if.mem_address, x.addr);
         @(posedge clk); #1;
         chk("rsp_valid", i, bus_if.rsp_valid, x.rv);
         if (x.rv) begin
            chk("rsp_id", i, bus_if.rsp_id, x.rid);
            chk("rsp_write", i, bus_if.rsp_write, x.rw);
            chk("rsp_rdata", i, bus_if.rsp_rdata, x.rd);
         end
      end

      // Reset during a locked, granted read.
      drive(2'b10, 2'b00, 2'b10, 16'h0010, 16'h0020, 16'h0, 16'h0);
      @(negedge clk);
      chk("mid_ready0", -1, bus_if.req_ready, 2'b10);
      @(posedge clk); #1;
      chk("mid_rsp0", -1, bus_if.rsp_valid, 1);
      drive(2'b11, 2'b00, 2'b10, 16'h0010, 16'h0020, 16'h0, 16'h0);
      @(negedge clk);
      chk("mid_ready1", -1, bus_if.req_ready, 2'b10);
      #1 reset = 1'b0;
      #1;
      chk("mid_rsp_drop", -1, bus_if.rsp_valid, 0);
      chk("mid_ready_drop", -1, bus_if.req_ready, 0);
      chk("mid_mem_reset", -1, bus_if.mem_reset, 1);
      chk("mid_mem_re", -1, bus_if.mem_read_enable, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("mid_clear_ready", -1, bus_if.req_ready, 0);
      chk("mid_clear_mem_reset", -1, bus_if.mem_reset, 1);
      @(posedge clk); #1;
      chk("mid_run_mem_reset", -1, bus_if.mem_reset, 0);
      @(negedge clk);
      chk("mid_post_ready", -1, bus_if.req_ready, 2'b01);
      chk("mid_post_addr", -1, bus_if.mem_address, 16'h0010);
      @(posedge clk); #1;
      chk("mid_post_rsp_valid", -1, bus_if.rsp_valid, 1);
      chk("mid_post_rsp_id", -1, bus_if.rsp_id, 0);
      chk("mid_post_rdata", -1, bus_if.rsp_rdata, 16'h0000);
      drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
